// File: rtl/irq_vec_pkg.sv
// Shared encodings for the interrupt vector controller: FSM states, vector
// width and the vector value used at reset.
package irq_vec_pkg;

   localparam int VEC_W = 6;
   localparam logic [VEC_W-1:0] VEC_RST = 6'h00;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_REQ       = 3'd1,
      ST_ACK       = 3'd2,
      ST_VECT      = 3'd3,
      ST_POST_RETI = 3'd4
   } state_t;

   // Line index i maps to vector address i+1; address 0 is the reset vector.
   function automatic logic [VEC_W-1:0] idx_to_vec(input logic [VEC_W-1:0] idx);
      return idx + 6'd1;
   endfunction

endpackage

// File: rtl/irq_vector_ctrl_if.sv
// Request/acknowledge bundle between the interrupt controller (slave side)
// and the core plus peripherals (master side).
interface irq_vector_ctrl_if #(
   parameter int NUM_IRQ = 45
);
   import irq_vec_pkg::*;

   logic [NUM_IRQ-1:0] irq_lines;
   logic               glob_int_en;
   logic               insn_boundary;
   logic               core_ack;
   logic               reti;
   logic               sleep_mode;
   logic               irq_req;
   logic [VEC_W-1:0]   irq_vector;
   logic               irqack;
   logic [VEC_W-1:0]   irqack_addr;
   logic               irq_busy;
   logic               wake;

   modport slave (
      input  irq_lines, glob_int_en, insn_boundary, core_ack, reti, sleep_mode,
      output irq_req, irq_vector, irqack, irqack_addr, irq_busy, wake
   );

   modport master (
      output irq_lines, glob_int_en, insn_boundary, core_ack, reti, sleep_mode,
      input  irq_req, irq_vector, irqack, irqack_addr, irq_busy, wake
   );

endinterface

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder over the interrupt request lines.
module irq_prio_enc
   import irq_vec_pkg::*;
#(
   parameter int NUM_IRQ = 45
) (
   input  logic [NUM_IRQ-1:0] lines,
   output logic               valid,
   output logic [VEC_W-1:0]   idx
);

   // Scan high to low so the last hit written is the lowest index.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (lines[i]) begin
            valid = 1'b1;
            idx   = VEC_W'(i);
         end
      end
   end

endmodule

// File: rtl/irq_vector_ctrl.sv
// Interrupt vector controller: arbitrates request lines at instruction
// boundaries and sequences request/ack/vectoring. Wake output under IRQ_WAKE_EN.
//
// state        | meaning
// IDLE         | waiting for an enabled request at an instruction boundary
// REQ          | irq_req high, latched vector offered to the core
// ACK          | one-cycle irqack to peripherals
// VECT         | core pushing PC and jumping; down-counter running
// POST_RETI    | after RETI, hold off until one instruction retires
module irq_vector_ctrl
   import irq_vec_pkg::*;
#(
   parameter int NUM_IRQ     = 45,
   parameter int VECT_CYCLES = 4
) (
   input  logic              cp2,
   input  logic              ireset,
   irq_vector_ctrl_if.slave  bus
);

   state_t           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [VEC_W-1:0] idx_q, idx_d;
   logic [VEC_W-1:0] vec_q, vec_d;
   logic [VEC_W-1:0] ack_addr_q, ack_addr_d;
   logic             req_q, req_d;
   logic             ack_q, ack_d;
   logic             busy_q;
   logic             enc_valid;
   logic [VEC_W-1:0] enc_idx;
   logic             line_hit;

   irq_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio_enc (
      .lines (bus.irq_lines),
      .valid (enc_valid),
      .idx   (enc_idx)
   );

   always_comb begin
      line_hit = 1'b0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         if (idx_q == VEC_W'(i)) line_hit = bus.irq_lines[i];
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      vec_d      = vec_q;
      ack_addr_d = ack_addr_q;
      req_d      = 1'b0;
      ack_d      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.reti) begin
               state_d = ST_POST_RETI;
            end else if (bus.glob_int_en && bus.insn_boundary && enc_valid) begin
               state_d = ST_REQ;
               idx_d   = enc_idx;
               vec_d   = idx_to_vec(enc_idx);
               req_d   = 1'b1;
            end
         end
         ST_REQ: begin
            // core_ack outranks a same-cycle withdrawal of the request.
            if (bus.core_ack) begin
               state_d    = ST_ACK;
               ack_d      = 1'b1;
               ack_addr_d = vec_q;
            end else if (!line_hit || !bus.glob_int_en) begin
               state_d = ST_IDLE;
            end else begin
               req_d = 1'b1;
            end
         end
         ST_ACK: begin
            state_d = ST_VECT;
            cnt_d   = 4'(VECT_CYCLES - 1);
         end
         ST_VECT: begin
            if (cnt_q == 4'd0) state_d = ST_IDLE;
            else               cnt_d   = cnt_q - 4'd1;
         end
         ST_POST_RETI: begin
            if (bus.insn_boundary) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge cp2) begin
      if (!ireset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 4'd0;
         idx_q      <= '0;
         vec_q      <= VEC_RST;
         ack_addr_q <= VEC_RST;
         req_q      <= 1'b0;
         ack_q      <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         vec_q      <= vec_d;
         ack_addr_q <= ack_addr_d;
         req_q      <= req_d;
         ack_q      <= ack_d;
         busy_q     <= (state_d != ST_IDLE);
      end
   end

   assign bus.irq_req     = req_q;
   assign bus.irq_vector  = vec_q;
   assign bus.irqack      = ack_q;
   assign bus.irqack_addr = ack_addr_q;
   assign bus.irq_busy    = busy_q;

`ifdef IRQ_WAKE_EN
   logic wake_q;

   always_ff @(posedge cp2) begin
      if (!ireset) wake_q <= 1'b0;
      else         wake_q <= bus.sleep_mode & (|bus.irq_lines);
   end

   assign bus.wake = wake_q;
`else
   logic unused_sleep;
   assign unused_sleep = bus.sleep_mode;
   assign bus.wake     = 1'b0;
`endif

endmodule

// File: tb/tb_irq_vector_ctrl.sv
// Directed bench for irq_vector_ctrl with hand-computed expectations.
module tb_irq_vector_ctrl;
   import irq_vec_pkg::*;

   localparam int NUM_IRQ = 45;

   logic cp2;
   logic ireset;
   int   n_chk;
   int   n_err;

   irq_vector_ctrl_if #(.NUM_IRQ(NUM_IRQ)) bus ();

   irq_vector_ctrl #(.NUM_IRQ(NUM_IRQ), .VECT_CYCLES(4)) dut (
      .cp2    (cp2),
      .ireset (ireset),
      .bus    (bus)
   );

   initial cp2 = 1'b0;
   always #5 cp2 = ~cp2;

`ifdef IRQ_WAKE_EN
   localparam logic WAKE_EXP = 1'b1;
`else
   localparam logic WAKE_EXP = 1'b0;
`endif

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge cp2);
      #1;
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_req"},  32'(bus.irq_req),     32'd0);
      chk({tag, "_vec"},  32'(bus.irq_vector),  32'd0);
      chk({tag, "_ack"},  32'(bus.irqack),      32'd0);
      chk({tag, "_addr"}, 32'(bus.irqack_addr), 32'd0);
      chk({tag, "_busy"}, 32'(bus.irq_busy),    32'd0);
      chk({tag, "_wake"}, 32'(bus.wake),        32'd0);
   endtask

   task automatic pulse_insn();
      bus.insn_boundary = 1'b1;
      tick();
      bus.insn_boundary = 1'b0;
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      ireset            = 1'b0;
      bus.irq_lines     = '0;
      bus.glob_int_en   = 1'b0;
      bus.insn_boundary = 1'b0;
      bus.core_ack      = 1'b0;
      bus.reti          = 1'b0;
      bus.sleep_mode    = 1'b0;
      tick();
      tick();
      chk_reset_outs("rst");
      ireset = 1'b1;

      // Grant: lines 0 and 4, lowest wins.
      bus.irq_lines   = 45'h11;
      bus.glob_int_en = 1'b1;
      pulse_insn();
      chk("grant_req",  32'(bus.irq_req),    32'd1);
      chk("grant_vec",  32'(bus.irq_vector), 32'h01);
      chk("grant_busy", 32'(bus.irq_busy),   32'd1);
      tick();
      chk("hold_req", 32'(bus.irq_req),    32'd1);
      chk("hold_vec", 32'(bus.irq_vector), 32'h01);

      // Acknowledge, then vectoring ignores insn_boundary/core_ack.
      bus.core_ack = 1'b1;
      tick();
      bus.core_ack = 1'b0;
      chk("ack",      32'(bus.irqack),      32'd1);
      chk("ack_addr", 32'(bus.irqack_addr), 32'h01);
      chk("ack_req",  32'(bus.irq_req),     32'd0);
      for (int i = 0; i < 4; i++) begin
         bus.insn_boundary = 1'b1;
         bus.core_ack      = 1'b1;
         tick();
         chk($sformatf("vect_busy%0d", i), 32'(bus.irq_busy), 32'd1);
         chk($sformatf("vect_ack%0d", i),  32'(bus.irqack),   32'd0);
         chk($sformatf("vect_req%0d", i),  32'(bus.irq_req),  32'd0);
      end
      bus.insn_boundary = 1'b0;
      bus.core_ack      = 1'b0;
      tick();
      chk("vect_done_busy", 32'(bus.irq_busy),    32'd0);
      chk("addr_hold",      32'(bus.irqack_addr), 32'h01);

      // Withdraw latched line before core_ack.
      pulse_insn();
      chk("w_req", 32'(bus.irq_req), 32'd1);
      bus.irq_lines = 45'h10;
      tick();
      chk("w_drop_req",  32'(bus.irq_req),    32'd0);
      chk("w_drop_busy", 32'(bus.irq_busy),   32'd0);
      chk("w_drop_ack",  32'(bus.irqack),     32'd0);
      chk("w_vec_hold",  32'(bus.irq_vector), 32'h01);

      // Frozen vector: higher priority arrives during REQ.
      pulse_insn();
      chk("f_vec", 32'(bus.irq_vector), 32'h05);
      bus.irq_lines = 45'h11;
      tick();
      chk("f_vec_frozen", 32'(bus.irq_vector), 32'h05);
      chk("f_req",        32'(bus.irq_req),    32'd1);
      bus.glob_int_en = 1'b0;
      tick();
      chk("g_drop_req", 32'(bus.irq_req), 32'd0);
      chk("g_drop_ack", 32'(bus.irqack),  32'd0);
      bus.glob_int_en = 1'b1;

      // core_ack beats a same-cycle line drop.
      bus.irq_lines = 45'h10;
      pulse_insn();
      bus.irq_lines = '0;
      bus.core_ack  = 1'b1;
      tick();
      bus.core_ack = 1'b0;
      chk("race_ack",  32'(bus.irqack),      32'd1);
      chk("race_addr", 32'(bus.irqack_addr), 32'h05);
      for (int i = 0; i < 5; i++) tick();
      chk("race_idle", 32'(bus.irq_busy), 32'd0);

      // Highest line index maps to vector 45.
      bus.irq_lines = 45'h1 << 44;
      pulse_insn();
      chk("top_vec", 32'(bus.irq_vector), 32'h2D);
      bus.irq_lines = '0;
      tick();
      chk("top_drop", 32'(bus.irq_busy), 32'd0);

      // RETI holds off the next grant by one instruction.
      bus.irq_lines = 45'h4;
      bus.reti      = 1'b1;
      tick();
      bus.reti = 1'b0;
      chk("reti_busy", 32'(bus.irq_busy), 32'd1);
      pulse_insn();
      chk("reti_no_req", 32'(bus.irq_req),  32'd0);
      chk("reti_idle",   32'(bus.irq_busy), 32'd0);
      pulse_insn();
      chk("reti_req", 32'(bus.irq_req),    32'd1);
      chk("reti_vec", 32'(bus.irq_vector), 32'h03);

      // Reset during ACK.
      bus.core_ack = 1'b1;
      tick();
      bus.core_ack = 1'b0;
      chk("pre_rst_ack",  32'(bus.irqack),      32'd1);
      chk("pre_rst_addr", 32'(bus.irqack_addr), 32'h03);
      ireset = 1'b0;
      tick();
      chk_reset_outs("ack_rst");
      ireset = 1'b1;
      tick();
      chk("post_rst_ack",  32'(bus.irqack),   32'd0);
      chk("post_rst_busy", 32'(bus.irq_busy), 32'd0);

      // Wake while sleeping with interrupts globally disabled.
      bus.glob_int_en = 1'b0;
      bus.irq_lines   = 45'h2;
      bus.sleep_mode  = 1'b1;
      tick();
      chk("wake",      32'(bus.wake),     32'(WAKE_EXP));
      chk("wake_busy", 32'(bus.irq_busy), 32'd0);
      bus.sleep_mode = 1'b0;
      tick();
      chk("wake_off", 32'(bus.wake), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/irq_vector_ctrl.md
IRQ_VECTOR_CTRL -- requirements
Module: irq_vector_ctrl

Interface
REQ-001 Parameter NUM_IRQ, 45, number of interrupt request lines; legal range 1..63.
REQ-002 Parameter VECT_CYCLES, 4, cycles the block stays busy after acknowledge while the core pushes PC and jumps; legal range 1..15.
REQ-003 cp2  in  1  single clock; all state updates on rising edge.
REQ-004 ireset  in  1  reset, synchronous, active-low.
REQ-005 irq_lines  in  NUM_IRQ  level requests from peripherals; bit i is vector address i+1.
REQ-006 glob_int_en  in  1  SREG I flag.
REQ-007 insn_boundary  in  1  one-cycle pulse when the core completes an instruction.
REQ-008 core_ack  in  1  one-cycle pulse when the core commits to vectoring.
REQ-009 reti  in  1  one-cycle pulse when the core executes RETI.
REQ-010 sleep_mode  in  1  core is in sleep.
REQ-011 irq_req  out  1  interrupt request to core.
REQ-012 irq_vector  out  6  vector address offered to core.
REQ-013 irqack  out  1  one-cycle acknowledge to peripherals.
REQ-014 irqack_addr  out  6  vector address qualifying irqack.
REQ-015 irq_busy  out  1  high in any state other than IDLE.
REQ-016 wake  out  1  wake-up request; present only under IRQ_WAKE_EN, tied 0 otherwise.

Function
REQ-017 States: IDLE, REQ, ACK, VECT, POST_RETI; all outputs registered.
REQ-018 Priority: lowest set index of irq_lines wins; irq_vector = index+1, zero-extended to 6 bits.
REQ-019 IDLE -> REQ when glob_int_en & insn_boundary & any irq_lines bit set; the winner index is latched in that cycle.
REQ-020 In REQ: irq_req=1 and irq_vector = latched vector, frozen; a higher-priority line arriving in REQ does not re-arbitrate.
REQ-021 REQ -> ACK on core_ack.
REQ-022 REQ -> IDLE, with no irqack, when the latched line or glob_int_en deasserts before core_ack; when core_ack arrives in the same cycle, core_ack wins.
REQ-023 ACK lasts exactly one cycle: irqack=1, irqack_addr = latched vector, irq_req=0; then -> VECT with down-counter loaded with VECT_CYCLES-1.
REQ-024 VECT decrements each cycle and -> IDLE the cycle after the counter reads 0; insn_boundary and core_ack are ignored in VECT.
REQ-025 reti in IDLE -> POST_RETI; in POST_RETI the next insn_boundary returns to IDLE and does not grant, so at least one instruction retires between interrupts.
REQ-026 reti in REQ, ACK or VECT is ignored.
REQ-027 irqack_addr holds its last value outside ACK; irq_vector holds its last value outside REQ.
REQ-028 Total latency: irq_req rises 1 cycle after the granting insn_boundary; irqack rises 1 cycle after core_ack.

Reset
REQ-029 When ireset=0 at a clock edge: state -> IDLE; counter -> 0; irq_req, irqack, irq_busy and wake -> 0; irq_vector and irqack_addr -> 6'h00.
REQ-030 Reset mid-REQ or mid-ACK aborts with no irqack issued after the reset edge.

Configuration
REQ-031 Macro IRQ_WAKE_EN defined: wake is registered and equals sleep_mode & (any irq_lines bit set), independent of glob_int_en and state.
REQ-032 IRQ_WAKE_EN undefined: no wake logic is compiled and wake is constant 0.

Structure
REQ-033 Package irq_vec_pkg holds the state encoding, VEC_W=6 and the reset vector constant 6'h00.
REQ-034 Sub-module irq_prio_enc: combinational lowest-index priority encoder with NUM_IRQ inputs, producing a valid flag and a 6-bit index.

Verification
REQ-035 irq_lines[0] and [4] set, glob_int_en=1, insn_boundary pulse -> irq_req=1 next cycle with irq_vector=6'h01.
REQ-036 In REQ, core_ack pulse -> irqack=1 for exactly 1 cycle with irqack_addr=6'h01; irq_busy stays high 4 more cycles, then IDLE.
REQ-037 In REQ, drop irq_lines[0] before core_ack -> irq_req=0 next cycle and no irqack; in REQ, raise irq_lines[0] while vector 6'h05 is offered -> irq_vector stays 6'h05.
REQ-038 reti in IDLE with irq_lines[2] set -> the first insn_boundary gives no irq_req; the second gives irq_vector=6'h03.
REQ-039 ireset=0 during ACK -> irqack=0 and all outputs at their reset values after the edge.
REQ-040 IRQ_WAKE_EN defined, sleep_mode=1, glob_int_en=0, irq_lines[1] set -> wake=1 next cycle; same stimulus without the macro -> wake=0.
